bconv3x3_bin_layer2: RTL and testbench

//  Streaming 3x3 binary convolution (XNOR-popcount-threshold), stride 1, no padding.

---
 rtl/bconv3x3_bin_layer2.sv | 121 ++++++++++++
 tb/tb_bconv3x3_bin_layer2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bconv3x3_bin_layer2.sv
// Streaming 3x3 XNOR-popcount-threshold binary convolution, stride 1, no padding.
// Define BCONV_RUNTIME_WEIGHTS_EN to add cfg_load/cfg_weights/cfg_threshold inputs.
module bconv3x3_bin_layer2 #(
   parameter int         IN_WIDTH  = 13,
   parameter int         IN_HEIGHT = 13,
   parameter logic [8:0] WEIGHTS   = 9'h1FF,
   parameter int         THRESHOLD = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       valid_in,
   input  logic       pixel_in,
`ifdef BCONV_RUNTIME_WEIGHTS_EN
   input  logic       cfg_load,
   input  logic [8:0] cfg_weights,
   input  logic [3:0] cfg_threshold,
`endif
   output logic       pixel_out,
   output logic       valid_out,
   output logic       frame_done
);

   localparam int CW = $clog2(IN_WIDTH);
   localparam int RW = $clog2(IN_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);

   logic [IN_WIDTH-1:0] lb_r1;
   logic [IN_WIDTH-1:0] lb_r2;
   logic [CW-1:0]       col;
   logic [RW-1:0]       row;
   logic [8:0]          win;
   logic [8:0]          win_nx;
   logic [8:0]          wts;
   logic [8:0]          match;
   logic [3:0]          pop;
   logic                thr_ok;
   logic                emit;
   logic                col_end;
   logic                row_end;

`ifdef BCONV_RUNTIME_WEIGHTS_EN
   localparam logic [3:0] THR_INIT =
      (THRESHOLD > 15) ? 4'd15 : 4'(THRESHOLD);

   logic [3:0] thr_q;
   logic [8:0] wts_q;

   // A load coinciding with valid_in still scores that window with the old set.
   always_ff @(posedge clk) begin
      if (reset) begin
         wts_q <= WEIGHTS;
         thr_q <= THR_INIT;
      end else if (cfg_load) begin
         wts_q <= cfg_weights;
         thr_q <= cfg_threshold;
      end
   end

   assign wts    = wts_q;
   assign thr_ok = (pop >= thr_q);
`else
   assign wts    = WEIGHTS;
   assign thr_ok = (int'({28'd0, pop}) >= THRESHOLD);
`endif

   assign col_end = (col == COL_LAST);
   assign row_end = (row == ROW_LAST);
   assign emit    = valid_in && (row >= ROW_TWO) && (col >= COL_TWO);

   // Bit k = 3*dy+dx; the new right column enters at bits 2/5/8.
   always_comb begin
      win_nx = win;
      if (valid_in) begin
         win_nx = {pixel_in, win[8:7],
                   lb_r1[col], win[5:4],
                   lb_r2[col], win[2:1]};
      end
   end

   always_comb begin
      match = ~(win_nx ^ wts);
      pop   = 4'd0;
      for (int k = 0; k < 9; k++) begin
         pop = pop + 4'(match[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lb_r1      <= '0;
         lb_r2      <= '0;
         win        <= '0;
         col        <= '0;
         row        <= '0;
         pixel_out  <= 1'b0;
         valid_out  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid_out  <= emit;
         frame_done <= emit && col_end && row_end;
         if (emit) begin
            pixel_out <= thr_ok;
         end
         if (valid_in) begin
            win        <= win_nx;
            lb_r2[col] <= lb_r1[col];
            lb_r1[col] <= pixel_in;
            if (col_end) begin
               col <= '0;
               row <= row_end ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bconv3x3_bin_layer2.sv
// Directed bench for bconv3x3_bin_layer2: three parameterisations share one stream.
// Instance a: defaults; b: WEIGHTS=0; c: WEIGHTS=0x155, THRESHOLD=9.
module tb_bconv3x3_bin_layer2;

   localparam int W = 13;
   localparam int H = 13;

   logic clk = 1'b0;
   logic reset;
   logic valid_in;
   logic pixel_in;
   logic po_a, vo_a, fd_a;
   logic po_b, vo_b, fd_b;
   logic po_c, vo_c, fd_c;
`ifdef BCONV_RUNTIME_WEIGHTS_EN
   logic       cfg_load;
   logic [8:0] cfg_weights;
   logic [3:0] cfg_threshold;
   logic       cfg_off = 1'b0;
`endif

   int n_assert = 0;
   int n_fail   = 0;
   int total    = 0;
   bit a_cfg    = 1'b0;

   always #5 clk = ~clk;

   bconv3x3_bin_layer2 u_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pixel_in(pixel_in),
`ifdef BCONV_RUNTIME_WEIGHTS_EN
      .cfg_load(cfg_load), .cfg_weights(cfg_weights),
      .cfg_threshold(cfg_threshold),
`endif
      .pixel_out(po_a), .valid_out(vo_a), .frame_done(fd_a)
   );

   bconv3x3_bin_layer2 #(.WEIGHTS(9'h000)) u_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pixel_in(pixel_in),
`ifdef BCONV_RUNTIME_WEIGHTS_EN
      .cfg_load(cfg_off), .cfg_weights(9'h000), .cfg_threshold(4'h0),
`endif
      .pixel_out(po_b), .valid_out(vo_b), .frame_done(fd_b)
   );

   bconv3x3_bin_layer2 #(.WEIGHTS(9'h155), .THRESHOLD(9)) u_c (
      .clk(clk), .reset(reset), .valid_in(valid_in), .pixel_in(pixel_in),
`ifdef BCONV_RUNTIME_WEIGHTS_EN
      .cfg_load(cfg_off), .cfg_weights(9'h000), .cfg_threshold(4'h0),
`endif
      .pixel_out(po_c), .valid_out(vo_c), .frame_done(fd_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // kind 0: zeros, 1: ones, 2: checkerboard. (i,j) is the window top-left.
   function automatic logic exp_px(input int inst, input int kind,
                                   input int i, input int j);
      bit ev;
      ev = ((i + j) % 2) == 0;
      case (inst)
         0:       return a_cfg ? (kind == 0)
                               : (kind == 1 || (kind == 2 && ev));
         1:       return (kind == 0 || (kind == 2 && !ev));
         default: return (kind == 2 && ev);
      endcase
   endfunction

   task automatic do_reset(input int n);
      reset    = 1'b1;
      valid_in = 1'b1;
      pixel_in = 1'b1;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         chk("rst_po", po_a, 0);
         chk("rst_vo", vo_a | vo_b | vo_c, 0);
         chk("rst_fd", fd_a | fd_b | fd_c, 0);
      end
      reset    = 1'b0;
      valid_in = 1'b0;
      pixel_in = 1'b0;
      a_cfg    = 1'b0;
   endtask

   task automatic run(input int kind, input int npix, input bit gaps,
                      input bit ld22);
      int   r, c, outs, fds, g;
      bit   em, ld;
      logic last_a;
      r = 0; c = 0; outs = 0; fds = 0;
      for (int n = 0; n < npix; n++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
               last_a   = po_a;
               valid_in = 1'b0;
               @(posedge clk); #1;
               chk("gap_vo", vo_a, 0);
               chk("gap_fd", fd_a, 0);
               chk("gap_hold", po_a, last_a);
            end
         end
         ld       = ld22 && r == 2 && c == 2;
         valid_in = 1'b1;
         pixel_in = (kind == 1) || (kind == 2 && ((r + c) % 2) == 0);
`ifdef BCONV_RUNTIME_WEIGHTS_EN
         cfg_load      = ld;
         cfg_weights   = 9'h000;
         cfg_threshold = 4'd9;
`endif
         @(posedge clk); #1;
         valid_in = 1'b0;
`ifdef BCONV_RUNTIME_WEIGHTS_EN
         cfg_load = 1'b0;
`endif
         em = (r >= 2) && (c >= 2);
         chk("vo_a", vo_a, em);
         chk("vo_bc", {vo_b, vo_c}, {em, em});
         if (em) begin
            outs++;
            chk("px_a", po_a, exp_px(0, kind, r - 2, c - 2));
            chk("px_b", po_b, exp_px(1, kind, r - 2, c - 2));
            chk("px_c", po_c, exp_px(2, kind, r - 2, c - 2));
         end
         chk("fd_a", fd_a, (r == H - 1 && c == W - 1));
         if (fd_a) begin
            fds++;
            chk("fd_last", outs, (W - 2) * (H - 2));
         end
         if (ld) a_cfg = 1'b1;
         if (c == W - 1) begin
            c = 0;
            r = (r == H - 1) ? 0 : r + 1;
         end else begin
            c++;
         end
      end
      if (npix == W * H) begin
         chk("outs", outs, (W - 2) * (H - 2));
         chk("fds", fds, 1);
      end
      total += outs;
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      pixel_in = 1'b0;
`ifdef BCONV_RUNTIME_WEIGHTS_EN
      cfg_load      = 1'b0;
      cfg_weights   = 9'h000;
      cfg_threshold = 4'd0;
`endif
      do_reset(2);

      run(1, W * H, 1'b0, 1'b0);
      run(0, W * H, 1'b0, 1'b0);
      run(2, W * H, 1'b0, 1'b0);
      run(1, W * H, 1'b1, 1'b0);

      run(1, 70, 1'b0, 1'b0);
      do_reset(3);
      run(0, W * H, 1'b0, 1'b0);
      total = 0;
      run(0, W * H, 1'b0, 1'b0);
      run(2, W * H, 1'b0, 1'b0);
      chk("b2b_total", total, 242);

`ifdef BCONV_RUNTIME_WEIGHTS_EN
      do_reset(1);
      run(1, W * H, 1'b0, 1'b0);
      cfg_load      = 1'b1;
      cfg_weights   = 9'h000;
      cfg_threshold = 4'd9;
      @(posedge clk); #1;
      cfg_load = 1'b0;
      a_cfg    = 1'b1;
      chk("cfg_vo", vo_a, 0);
      run(1, W * H, 1'b0, 1'b0);
      run(0, W * H, 1'b0, 1'b0);
      do_reset(1);
      run(1, W * H, 1'b0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
